rom_reader: RTL and testbench

ROM_READER -- requirements
Module: rom_reader

---
 rtl/rom_reader_pkg.sv | 19 +
 rtl/rom_reader_if.sv | 46 ++++
 rtl/rom_reader_rom.sv | 34 +++
 rtl/rom_reader.sv | 122 ++++++++++++
 tb/tb_rom_reader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader_pkg
// Brief    : Shared state encoding and default widths for the ROM burst reader.
// Revision : 1.0
// ============================================================================
package rom_reader_pkg;

    localparam int c_DEFAULT_AW = 16;
    localparam int c_DEFAULT_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader_if
// Brief    : Control, ROM-side and stream-side signals of the ROM burst reader.
// Revision : 1.0
// ============================================================================
interface rom_reader_if
    import rom_reader_pkg::*;
#(
    parameter int AW = c_DEFAULT_AW,
    parameter int DW = c_DEFAULT_DW
) ();

    logic          START;
    logic [AW-1:0] BASE;
    logic [AW-1:0] LEN;
    logic          ABORT;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] OUT;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          OUT_LAST;
    logic          BUSY;
    logic          DONE;

    // Reader side
    modport slave (
        input  START, BASE, LEN, ABORT, D, OUT_READY,
        output A, OUT, OUT_VALID, OUT_LAST, BUSY, DONE
    );

    // Requester / consumer side
    modport master (
        output START, BASE, LEN, ABORT, OUT_READY,
        input  A, OUT, OUT_VALID, OUT_LAST, BUSY, DONE
    );

    // Combinational ROM responder
    modport rom (
        input  A,
        output D
    );

endinterface
`default_nettype wire

// File: rtl/rom_reader_rom.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader_rom
// Brief    : Small combinational ROM image answering the reader's address bus.
// Revision : 1.0
// ============================================================================
module rom_reader_rom
    import rom_reader_pkg::*;
#(
    parameter int AW = c_DEFAULT_AW,
    parameter int DW = c_DEFAULT_DW
) (
    input  wire logic [AW-1:0] A,
    output logic      [DW-1:0] D
);

    always_comb begin
        D = '0;
        case (A)
            AW'(0):  D = DW'(2);
            AW'(1):  D = DW'(0);
            AW'(2):  D = DW'(104);
            AW'(3):  D = DW'(2);
            AW'(4):  D = DW'(12);
            AW'(5):  D = DW'(96);
            AW'(22): D = DW'(8);
            AW'(23): D = DW'(36);
            AW'(24): D = DW'(145);
            default: D = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rom_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader
// Brief    : Streams a burst of words from a combinational ROM onto a
//            valid/ready output with one-word buffering, abort and done pulse.
// Revision : 1.0
// ============================================================================
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int AW = c_DEFAULT_AW,
    parameter int DW = c_DEFAULT_DW
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    rom_reader_if.slave   bus
);

    state_t        state_q,     state_d;
    logic [AW-1:0] a_q,         a_d;
    logic [AW-1:0] rem_q,       rem_d;
    logic [DW-1:0] out_q,       out_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q,  out_last_d;
    logic          done_q,      done_d;

    logic          w_hs;
    logic          w_load;

    assign w_hs   = out_valid_q & bus.OUT_READY;
    // The output register can take a new word when empty or being emptied.
    assign w_load = ~out_valid_q | w_hs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            a_q         <= '0;
            rem_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            rem_q       <= rem_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        rem_d       = rem_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    if (bus.LEN != '0) begin
                        a_d     = bus.BASE;
                        rem_d   = bus.LEN;
                        state_d = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            FETCH: begin
                if (bus.ABORT) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    rem_d       = '0;
                    state_d     = IDLE;
                end else if (w_load) begin
                    out_d       = bus.D;
                    out_valid_d = 1'b1;
                    out_last_d  = (rem_q == AW'(1));
                    a_d         = a_q + AW'(1);
                    rem_d       = rem_q - AW'(1);
                    if (rem_q == AW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Abort wins over a handshake on the same edge.
                if (bus.ABORT) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end else if (w_hs && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.A         = a_q;
    assign bus.OUT       = out_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_LAST  = out_last_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_reader
// Brief    : Self-checking bench for rom_reader: directed table, corner
//            sequences and randomized bursts against an address-image model.
// Revision : 1.0
// ============================================================================
module tb_rom_reader;

    logic CLK;
    logic RST;

    int total;
    int bad;

    rom_reader_if #(.AW(16), .DW(16)) bus ();

    rom_reader #(.AW(16), .DW(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    rom_reader_rom #(.AW(16), .DW(16)) u_rom (
        .A (bus.A),
        .D (bus.D)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference image: the words a burst must deliver are img[(BASE+i) mod 2^16].
    logic [15:0] img [0:31];

    function automatic logic [15:0] model_rom(input logic [15:0] addr);
        return (addr < 16'd32) ? img[addr[4:0]] : 16'd0;
    endfunction

    typedef struct {
        logic [15:0]      base;
        logic [15:0]      len;
        int               stall;
        int               n;
        logic [4:0][15:0] w;
    } vec_t;

    vec_t vecs [6];

    logic [15:0] got_q [$];
    int          n_done;
    bit          last_ok;
    bit          stable_ok;
    bit          busy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] base, input logic [15:0] len, input int stall,
                                input int n, input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
        vec_t v;
        v.base = base; v.len = len; v.stall = stall; v.n = n;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        return v;
    endfunction

    // One burst: collects handshaken words, counts DONE pulses and watches stall stability.
    task automatic run_burst(input logic [15:0] base, input logic [15:0] len,
                             input int stall, input bit rnd);
        logic [15:0] prev_out;
        logic        prev_last;
        bit          stalled_prev;
        logic        rdy;
        int          post;
        got_q.delete();
        n_done = 0; last_ok = 1; stable_ok = 1; busy_seen = 0;
        stalled_prev = 0; prev_out = '0; prev_last = 0; post = -1;
        @(negedge CLK);
        bus.START = 1'b1; bus.BASE = base; bus.LEN = len; bus.OUT_READY = 1'b0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(negedge CLK);
            bus.START = 1'b0;
            if (bus.BUSY === 1'b1) busy_seen = 1;
            if (bus.DONE === 1'b1) begin
                n_done++;
                if (post < 0) post = 4;
            end
            if (stalled_prev && (bus.OUT_VALID !== 1'b1 || bus.OUT !== prev_out ||
                                 bus.OUT_LAST !== prev_last))
                stable_ok = 0;
            if (cyc < stall + 1) rdy = 1'b0;
            else if (rnd)        rdy = 1'($urandom_range(0, 1));
            else                 rdy = 1'b1;
            bus.OUT_READY = rdy;
            if (bus.OUT_VALID === 1'b1 && rdy) begin
                got_q.push_back(bus.OUT);
                if (bus.OUT_LAST !== (got_q.size() == int'(len))) last_ok = 0;
            end
            stalled_prev = (bus.OUT_VALID === 1'b1) && !rdy;
            prev_out     = bus.OUT;
            prev_last    = bus.OUT_LAST;
            if (post > 0) begin
                post--;
                if (post == 0) break;
            end
        end
        bus.OUT_READY = 1'b0;
    endtask

    initial begin
        logic [15:0] rb, rl;
        int          rs;
        logic [31:0] g;
        bit          quiet;

        total = 0; bad = 0;
        for (int i = 0; i < 32; i++) img[i] = 16'd0;
        img[0] = 16'd2;  img[1] = 16'd0;  img[2] = 16'd104;
        img[3] = 16'd2;  img[4] = 16'd12; img[5] = 16'd96;
        img[22] = 16'd8; img[23] = 16'd36; img[24] = 16'd145;

        vecs[0] = mk(16'd0,      16'd3, 0, 3, 16'd2,  16'd0,  16'd104, 16'd0,   16'd0);
        vecs[1] = mk(16'd22,     16'd3, 3, 3, 16'd8,  16'd36, 16'd145, 16'd0,   16'd0);
        vecs[2] = mk(16'hFFFF,   16'd2, 0, 2, 16'd0,  16'd2,  16'd0,   16'd0,   16'd0);
        vecs[3] = mk(16'd3,      16'd1, 1, 1, 16'd2,  16'd0,  16'd0,   16'd0,   16'd0);
        vecs[4] = mk(16'd0,      16'd0, 0, 0, 16'd0,  16'd0,  16'd0,   16'd0,   16'd0);
        vecs[5] = mk(16'd21,     16'd5, 2, 5, 16'd0,  16'd8,  16'd36,  16'd145, 16'd0);

        bus.START = 0; bus.BASE = '0; bus.LEN = '0; bus.ABORT = 0; bus.OUT_READY = 0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_a",     32'(bus.A), 0);
        check("rst_out",   32'(bus.OUT), 0);
        check("rst_valid", 32'(bus.OUT_VALID), 0);
        check("rst_last",  32'(bus.OUT_LAST), 0);
        check("rst_busy",  32'(bus.BUSY), 0);
        check("rst_done",  32'(bus.DONE), 0);
        RST = 1'b0;

        // Directed table
        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].base, vecs[v].len, vecs[v].stall, 1'b0);
            check($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'(vecs[v].n));
            for (int i = 0; i < vecs[v].n; i++) begin
                g = (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF;
                check($sformatf("vec%0d_word%0d", v, i), g, 32'(vecs[v].w[i]));
            end
            check($sformatf("vec%0d_done", v),   32'(n_done), 1);
            check($sformatf("vec%0d_last", v),   32'(last_ok), 1);
            check($sformatf("vec%0d_stable", v), 32'(stable_ok), 1);
            check($sformatf("vec%0d_busy", v),   32'(busy_seen), 32'(vecs[v].len != 0));
        end

        // Exact latency and throughput; a START while busy must be ignored
        @(negedge CLK);
        bus.OUT_READY = 1; bus.START = 1; bus.BASE = 16'd0; bus.LEN = 16'd3;
        @(negedge CLK);
        bus.START = 0;
        check("lat_busy_k1",  32'(bus.BUSY), 1);
        check("lat_valid_k1", 32'(bus.OUT_VALID), 0);
        check("lat_a_k1",     32'(bus.A), 0);
        bus.START = 1; bus.BASE = 16'd22; bus.LEN = 16'd1;
        @(negedge CLK);
        bus.START = 0;
        check("lat_valid_k2", 32'(bus.OUT_VALID), 1);
        check("lat_out_k2",   32'(bus.OUT), 2);
        check("lat_last_k2",  32'(bus.OUT_LAST), 0);
        @(negedge CLK);
        check("lat_out_k3",   32'(bus.OUT), 0);
        check("lat_valid_k3", 32'(bus.OUT_VALID), 1);
        @(negedge CLK);
        check("lat_out_k4",   32'(bus.OUT), 104);
        check("lat_last_k4",  32'(bus.OUT_LAST), 1);
        @(negedge CLK);
        check("lat_done_k5",  32'(bus.DONE), 1);
        check("lat_valid_k5", 32'(bus.OUT_VALID), 0);
        check("lat_busy_k5",  32'(bus.BUSY), 0);
        @(negedge CLK);
        check("lat_done_k6",  32'(bus.DONE), 0);

        // Address wrap at the top of the space
        bus.START = 1; bus.BASE = 16'hFFFF; bus.LEN = 16'd2;
        @(negedge CLK);
        bus.START = 0;
        check("wrap_a0", 32'(bus.A), 32'hFFFF);
        @(negedge CLK);
        check("wrap_a1",   32'(bus.A), 0);
        check("wrap_out0", 32'(bus.OUT), 0);
        @(negedge CLK);
        check("wrap_out1",  32'(bus.OUT), 2);
        check("wrap_last1", 32'(bus.OUT_LAST), 1);
        @(negedge CLK);
        check("wrap_done", 32'(bus.DONE), 1);

        // Abort after the second handshake, with a simultaneous START
        @(negedge CLK);
        bus.START = 1; bus.BASE = 16'd0; bus.LEN = 16'd6;
        @(negedge CLK);
        bus.START = 0;
        repeat (3) @(negedge CLK);
        check("abort_pre_out", 32'(bus.OUT), 104);
        bus.ABORT = 1; bus.START = 1; bus.BASE = 16'd3; bus.LEN = 16'd1;
        @(negedge CLK);
        bus.ABORT = 0; bus.START = 0;
        check("abort_valid", 32'(bus.OUT_VALID), 0);
        check("abort_busy",  32'(bus.BUSY), 0);
        quiet = 1;
        for (int i = 0; i < 4; i++) begin
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.OUT_VALID !== 1'b0) quiet = 0;
            @(negedge CLK);
        end
        check("abort_quiet", 32'(quiet), 1);
        run_burst(16'd3, 16'd1, 0, 1'b0);
        check("after_abort_count", 32'(got_q.size()), 1);
        g = (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD_BEEF;
        check("after_abort_word", g, 2);
        check("after_abort_last", 32'(last_ok), 1);
        check("after_abort_done", 32'(n_done), 1);

        // Randomized bursts against the image model
        for (int t = 0; t < 24; t++) begin
            rb = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3))
                                              : 16'($urandom_range(0, 30));
            rl = 16'($urandom_range(0, 8));
            rs = int'($urandom_range(0, 2));
            run_burst(rb, rl, rs, 1'b1);
            check($sformatf("rnd%0d_count", t), 32'(got_q.size()), 32'(rl));
            for (int i = 0; i < int'(rl); i++) begin
                g = (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF;
                check($sformatf("rnd%0d_word%0d", t, i), g, 32'(model_rom(16'(rb + 16'(i)))));
            end
            check($sformatf("rnd%0d_done", t),   32'(n_done), 1);
            check($sformatf("rnd%0d_last", t),   32'(last_ok), 1);
            check($sformatf("rnd%0d_stable", t), 32'(stable_ok), 1);
            check($sformatf("rnd%0d_busy", t),   32'(busy_seen), 32'(rl != 0));
        end

        // Reset in the middle of a stalled burst, overriding a START
        @(negedge CLK);
        bus.START = 1; bus.BASE = 16'd22; bus.LEN = 16'd3; bus.OUT_READY = 0;
        @(negedge CLK);
        bus.START = 0;
        repeat (2) @(negedge CLK);
        check("midrst_pre_valid", 32'(bus.OUT_VALID), 1);
        RST = 1; bus.START = 1; bus.BASE = 16'd0; bus.LEN = 16'd2;
        @(negedge CLK);
        RST = 0; bus.START = 0;
        check("midrst_a",     32'(bus.A), 0);
        check("midrst_out",   32'(bus.OUT), 0);
        check("midrst_valid", 32'(bus.OUT_VALID), 0);
        check("midrst_last",  32'(bus.OUT_LAST), 0);
        check("midrst_busy",  32'(bus.BUSY), 0);
        check("midrst_done",  32'(bus.DONE), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
